// File: rtl/uart_pkg.sv
// Definitions shared by the UART receiver and transmitter: FSM state encodings
// and the default baud divider.
package uart_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } uart_state_t;

    localparam int DEFAULT_CD_MAX   = 10416;
    localparam int DEFAULT_CD_WIDTH = 16;

endpackage

// File: rtl/uart_sync.sv
// Two-flop synchronizer for the asynchronous serial line; resets to the idle
// (high) level so a reset never looks like a start edge.
module uart_sync (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_d,
    output logic o_q
);

    logic [1:0] r_sync;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_sync <= 2'b11;
        end else begin
            r_sync <= {r_sync[0], i_d};
        end
    end

    assign o_q = r_sync[1];

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver: mid-bit sampling via a baud counter, single-entry output
// buffer with valid/ack handshake, frame-error pulse and sticky overrun flag.
module uart_rx
    import uart_pkg::*;
#(
    parameter int CD_MAX   = DEFAULT_CD_MAX,
    parameter int CD_WIDTH = DEFAULT_CD_WIDTH
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx,
    output logic [7:0] rbus,
    output logic       valid,
    input  logic       ack,
    output logic       frame_err,
    output logic       overrun,
    output logic       busy
);

    localparam logic [CD_WIDTH-1:0] CD_FULL = CD_WIDTH'(CD_MAX);
    localparam logic [CD_WIDTH-1:0] CD_HALF = CD_WIDTH'(CD_MAX / 2);

    uart_state_t         r_state;
    uart_state_t         w_nextState;
    logic [CD_WIDTH-1:0] r_cdCount;
    logic [CD_WIDTH-1:0] w_nextCd;
    logic [2:0]          r_bitCount;
    logic [2:0]          w_nextBit;
    logic [7:0]          r_shift;
    logic [7:0]          w_nextShift;
    logic [7:0]          r_rbus;
    logic                r_valid;
    logic                r_frameErr;
    logic                r_overrun;
    logic                w_rxSync;
    logic                w_stopSample;

    uart_sync u_sync (
        .i_clk (clk),
        .i_rst (rst),
        .i_d   (rx),
        .o_q   (w_rxSync)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= IDLE;
            r_cdCount  <= '0;
            r_bitCount <= '0;
            r_shift    <= '0;
        end else begin
            r_state    <= w_nextState;
            r_cdCount  <= w_nextCd;
            r_bitCount <= w_nextBit;
            r_shift    <= w_nextShift;
        end
    end

    // START samples at half a bit so every later sample lands mid-bit.
    always_comb begin
        w_nextState  = r_state;
        w_nextCd     = r_cdCount;
        w_nextBit    = r_bitCount;
        w_nextShift  = r_shift;
        w_stopSample = 1'b0;
        case (r_state)
            IDLE: begin
                w_nextCd  = '0;
                w_nextBit = '0;
                if (!w_rxSync) begin
                    w_nextState = START;
                end
            end
            START: begin
                if (r_cdCount == CD_HALF) begin
                    w_nextCd    = '0;
                    w_nextBit   = '0;
                    w_nextState = w_rxSync ? IDLE : DATA;
                end else begin
                    w_nextCd = r_cdCount + 1'b1;
                end
            end
            DATA: begin
                if (r_cdCount == CD_FULL) begin
                    w_nextCd    = '0;
                    w_nextShift = {w_rxSync, r_shift[7:1]};
                    w_nextBit   = r_bitCount + 1'b1;
                    if (r_bitCount == 3'd7) begin
                        w_nextState = STOP;
                    end
                end else begin
                    w_nextCd = r_cdCount + 1'b1;
                end
            end
            STOP: begin
                if (r_cdCount == CD_FULL) begin
                    w_nextCd     = '0;
                    w_stopSample = 1'b1;
                    w_nextState  = IDLE;
                end else begin
                    w_nextCd = r_cdCount + 1'b1;
                end
            end
            default: begin
                w_nextState = IDLE;
            end
        endcase
    end

    // A load in the same cycle as an ack overrides the ack's clear of valid.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rbus     <= '0;
            r_valid    <= 1'b0;
            r_frameErr <= 1'b0;
            r_overrun  <= 1'b0;
        end else begin
            r_frameErr <= w_stopSample && !w_rxSync;
            if (ack && r_valid) begin
                r_valid   <= 1'b0;
                r_overrun <= 1'b0;
            end
            if (w_stopSample && w_rxSync) begin
                if (!r_valid || ack) begin
                    r_rbus  <= r_shift;
                    r_valid <= 1'b1;
                end else begin
                    r_overrun <= 1'b1;
                end
            end
        end
    end

    assign rbus      = r_rbus;
    assign valid     = r_valid;
    assign frame_err = r_frameErr;
    assign overrun   = r_overrun;
    assign busy      = (r_state != IDLE);

endmodule
